// File: rtl/dap_sched_pkg.sv
// rtl/dap_sched_pkg.sv - DAP scheduler shared types, command IDs and worker map
package dap_sched_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_BUSY     = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ST_OK          = 2'd0,
        ST_UNSUPPORTED = 2'd1,
        ST_TIMEOUT     = 2'd2,
        ST_ABORTED     = 2'd3
    } resp_status_e;

    localparam logic [7:0] ID_INFO               = 8'h00;
    localparam logic [7:0] ID_HOST_STATUS        = 8'h01;
    localparam logic [7:0] ID_CONNECT            = 8'h02;
    localparam logic [7:0] ID_DISCONNECT         = 8'h03;
    localparam logic [7:0] ID_TRANSFER_CONFIGURE = 8'h04;
    localparam logic [7:0] ID_TRANSFER           = 8'h05;
    localparam logic [7:0] ID_TRANSFER_BLOCK     = 8'h06;
    localparam logic [7:0] ID_WRITE_ABORT        = 8'h08;
    localparam logic [7:0] ID_DELAY              = 8'h09;
    localparam logic [7:0] ID_SWJ_PINS           = 8'h10;
    localparam logic [7:0] ID_SWJ_CLOCK          = 8'h11;
    localparam logic [7:0] ID_SWJ_SEQUENCE       = 8'h12;
    localparam logic [7:0] ID_SWD_CONFIGURE      = 8'h13;
    localparam logic [7:0] ID_JTAG_SEQUENCE      = 8'h14;
    localparam logic [7:0] ID_JTAG_CONFIGURE     = 8'h15;
    localparam logic [7:0] ID_SWD_SEQUENCE       = 8'h1D;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } worker_sel_t;

    // The one place that binds command IDs to worker slots.
    function automatic worker_sel_t cmd_to_worker(input logic [7:0] id);
        worker_sel_t s;
        s.hit = 1'b1;
        s.idx = '0;
        case (id)
            ID_INFO:               s.idx = 4'd0;
            ID_CONNECT:            s.idx = 4'd1;
            ID_DISCONNECT:         s.idx = 4'd2;
            ID_TRANSFER:           s.idx = 4'd3;
            ID_SWJ_PINS:           s.idx = 4'd4;
            ID_SWJ_CLOCK:          s.idx = 4'd5;
            ID_SWJ_SEQUENCE:       s.idx = 4'd6;
            ID_SWD_CONFIGURE:      s.idx = 4'd7;
            ID_JTAG_CONFIGURE:     s.idx = 4'd8;
            ID_TRANSFER_BLOCK:     s.idx = 4'd9;
            ID_TRANSFER_CONFIGURE: s.idx = 4'd10;
            ID_HOST_STATUS:        s.idx = 4'd11;
            ID_WRITE_ABORT:        s.idx = 4'd12;
            ID_DELAY:              s.idx = 4'd13;
            ID_JTAG_SEQUENCE:      s.idx = 4'd14;
            ID_SWD_SEQUENCE:       s.idx = 4'd15;
            default:               s.hit = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dap_sched_timer.sv
// rtl/dap_sched_timer.sv - saturating microsecond counter with limit compare
module dap_sched_timer #(
    parameter logic [31:0] LIMIT = 32'd100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

    // Fires on the tick that would make count reach LIMIT; LIMIT of 0 never fires.
    assign expire = (LIMIT != 32'd0) && tick && (count == LIMIT - 32'd1);

endmodule

// File: rtl/dap_cmd_scheduler.sv
// rtl/dap_cmd_scheduler.sv - DAP command dispatcher, stream router and response descriptor
import dap_sched_pkg::*;

module dap_cmd_scheduler #(
    parameter int          NUM_WORKERS = 16,
    parameter int          LEN_W       = 10,
    parameter logic [31:0] TIMEOUT_US  = 32'd100000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         us_tick,
    input  logic                         enable,
    input  logic                         dap_in_tvalid,
    input  logic [7:0]                   dap_in_tdata,
    output logic                         dap_in_tready,
    input  logic [NUM_WORKERS-1:0]       worker_tready,
    input  logic [NUM_WORKERS*LEN_W-1:0] worker_len,
    output logic [NUM_WORKERS-1:0]       start,
    input  logic [NUM_WORKERS-1:0]       done,
    output logic                         abort,
    output logic                         busy,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [7:0]                   resp_cmd,
    output logic [1:0]                   resp_status,
    output logic [LEN_W-1:0]             resp_len
);

    state_e           state, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hit_q, hit_d;
    resp_status_e     status_q, status_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             timer_clr;
    logic             timer_expire;
    worker_sel_t      sel;

    dap_sched_timer #(
        .LIMIT (TIMEOUT_US)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (timer_clr),
        .tick   (us_tick && (state == S_BUSY)),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cmd_q    <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            status_q <= ST_OK;
            len_q    <= '0;
        end else begin
            state    <= state_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            status_q <= status_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        sel           = cmd_to_worker(dap_in_tdata);
        state_d       = state;
        cmd_d         = cmd_q;
        idx_d         = idx_q;
        hit_d         = hit_q;
        status_d      = status_q;
        len_d         = len_q;
        dap_in_tready = 1'b0;
        start         = '0;
        abort         = 1'b0;
        timer_clr     = 1'b0;
        case (state)
            S_IDLE: begin
                dap_in_tready = enable;
                if (enable && dap_in_tvalid) begin
                    cmd_d     = dap_in_tdata;
                    hit_d     = sel.hit && (32'(sel.idx) < NUM_WORKERS);
                    idx_d     = sel.idx;
                    timer_clr = 1'b1;
                    state_d   = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (hit_q) begin
                    start[idx_q] = 1'b1;
                    state_d      = S_BUSY;
                end else begin
                    status_d = ST_UNSUPPORTED;
                    len_d    = '0;
                    state_d  = S_RESP;
                end
            end
            S_BUSY: begin
                // A done in the same cycle as an abort cause wins.
                dap_in_tready = worker_tready[idx_q];
                if (done[idx_q]) begin
                    len_d    = worker_len[32'(idx_q)*LEN_W +: LEN_W];
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (!enable) begin
                    abort    = 1'b1;
                    status_d = ST_ABORTED;
                    len_d    = '0;
                    state_d  = S_RESP;
                end else if (timer_expire) begin
                    abort    = 1'b1;
                    status_d = ST_TIMEOUT;
                    len_d    = '0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign resp_valid  = (state == S_RESP);
    assign resp_cmd    = cmd_q;
    assign resp_status = status_q;
    assign resp_len    = len_q;

endmodule

// File: tb/tb_dap_cmd_scheduler.sv
// tb/tb_dap_cmd_scheduler.sv - randomized self-checking bench for dap_cmd_scheduler
module tb_dap_cmd_scheduler;

    localparam int NW   = 16;
    localparam int LW   = 10;
    localparam int TO_I = 5;

    logic              clk;
    logic              resetn;
    logic              us_tick;
    logic              enable;
    logic              dap_in_tvalid;
    logic [7:0]        dap_in_tdata;
    logic              dap_in_tready;
    logic [NW-1:0]     worker_tready;
    logic [NW*LW-1:0]  worker_len;
    logic [NW-1:0]     start;
    logic [NW-1:0]     done;
    logic              abort;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [7:0]        resp_cmd;
    logic [1:0]        resp_status;
    logic [LW-1:0]     resp_len;

    dap_cmd_scheduler #(
        .NUM_WORKERS (NW),
        .LEN_W       (LW),
        .TIMEOUT_US  (32'(TO_I))
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .us_tick       (us_tick),
        .enable        (enable),
        .dap_in_tvalid (dap_in_tvalid),
        .dap_in_tdata  (dap_in_tdata),
        .dap_in_tready (dap_in_tready),
        .worker_tready (worker_tready),
        .worker_len    (worker_len),
        .start         (start),
        .done          (done),
        .abort         (abort),
        .busy          (busy),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_cmd      (resp_cmd),
        .resp_status   (resp_status),
        .resp_len      (resp_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected per-cycle outputs, written by the driver, checked at negedge.
    logic          chk_en = 1'b0;
    logic          exp_tready, exp_busy, exp_abort, exp_rv;
    logic [NW-1:0] exp_start;
    logic [7:0]    exp_cmd;
    logic [1:0]    exp_status;
    logic [LW-1:0] exp_len;

    // Observations for the literal pins.
    int            start_cycles, abort_cnt;
    logic [NW-1:0] obs_start;
    logic [7:0]    obs_cmd;
    logic [1:0]    obs_status;
    logic [LW-1:0] obs_len;

    logic [7:0] id_table [NW] = '{8'h00, 8'h02, 8'h03, 8'h05, 8'h10, 8'h11, 8'h12, 8'h13,
                                   8'h15, 8'h06, 8'h04, 8'h01, 8'h08, 8'h09, 8'h14, 8'h1D};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [7:0] id, output logic hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NW; i++) begin
            if (id_table[i] == id) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("dap_in_tready", 32'(dap_in_tready), 32'(exp_tready));
            check("busy", 32'(busy), 32'(exp_busy));
            check("abort", 32'(abort), 32'(exp_abort));
            check("start", 32'(start), 32'(exp_start));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("resp_cmd", 32'(resp_cmd), 32'(exp_cmd));
                check("resp_status", 32'(resp_status), 32'(exp_status));
                check("resp_len", 32'(resp_len), 32'(exp_len));
            end
            if (start != '0) begin
                start_cycles++;
                obs_start = start;
            end
            if (abort) abort_cnt++;
            if (resp_valid) begin
                obs_cmd    = resp_cmd;
                obs_status = resp_status;
                obs_len    = resp_len;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic tr, input logic bz, input logic ab, input logic [NW-1:0] st, input logic rv);
        exp_tready = tr;
        exp_busy   = bz;
        exp_abort  = ab;
        exp_start  = st;
        exp_rv     = rv;
    endtask

    task automatic rand_lens(input int idx, input logic [LW-1:0] wlen);
        for (int w = 0; w < NW; w++)
            worker_len[w*LW +: LW] = (w == idx) ? wlen : LW'($urandom);
    endtask

    // done_at / en_drop: BUSY cycle index, -1 = never.
    task automatic run_cmd(input logic [7:0] id, input int done_at, input int en_drop,
                           input int tick_pct, input logic [LW-1:0] wlen, input int ready_wait);
        logic hit;
        int   idx, c, ticks;
        logic fin, dn, en, tk;
        lookup(id, hit, idx);
        start_cycles = 0;
        abort_cnt    = 0;
        obs_start    = '0;
        step();
        enable = 1'b1; dap_in_tvalid = 1'b1; dap_in_tdata = id; us_tick = 1'b0;
        resp_ready = 1'b0; done = NW'($urandom); worker_tready = NW'($urandom);
        set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        dap_in_tvalid = 1'($urandom); dap_in_tdata = 8'($urandom); done = NW'($urandom);
        set_exp(1'b0, 1'b1, 1'b0, hit ? (NW'(1) << idx) : '0, 1'b0);
        exp_cmd = id;
        if (hit) begin
            c = 0; ticks = 0; fin = 1'b0;
            while (!fin) begin
                step();
                tk = (32'($urandom_range(0, 99)) < 32'(tick_pct));
                dn = (c == done_at);
                en = !(en_drop >= 0 && c >= en_drop);
                us_tick = tk; enable = en; dap_in_tvalid = 1'($urandom);
                dap_in_tdata = 8'($urandom); worker_tready = NW'($urandom);
                done = NW'($urandom);
                done[idx] = dn;
                rand_lens(idx, wlen);
                if (tk) ticks++;
                fin = 1'b1;
                if (dn) begin
                    exp_status = 2'd0; exp_len = wlen;
                end else if (!en) begin
                    exp_status = 2'd3; exp_len = '0;
                end else if (tk && ticks == TO_I) begin
                    exp_status = 2'd2; exp_len = '0;
                end else begin
                    fin = 1'b0;
                end
                set_exp(worker_tready[idx], 1'b1, fin && !dn, '0, 1'b0);
                c++;
                if (c > 500) begin
                    check("busy_bound", 32'(c), 32'd500);
                    fin = 1'b1;
                end
            end
        end else begin
            exp_status = 2'd1; exp_len = '0;
        end
        for (int r = 0; r <= ready_wait; r++) begin
            step();
            resp_ready = (r == ready_wait); dap_in_tvalid = 1'($urandom);
            dap_in_tdata = 8'($urandom); enable = 1'($urandom); us_tick = 1'($urandom);
            done = NW'($urandom); worker_tready = NW'($urandom); worker_len = {5{32'($urandom)}};
            set_exp(1'b0, 1'b1, 1'b0, '0, 1'b1);
        end
        step();
        resp_ready = 1'b0; dap_in_tvalid = 1'b0; enable = 1'b1; done = NW'($urandom);
        set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    rid;
        logic          h;
        int            ix;
        resetn = 1'b0; us_tick = 1'b0; enable = 1'b0; dap_in_tvalid = 1'b0; dap_in_tdata = '0;
        worker_tready = '0; worker_len = '0; done = '0; resp_ready = 1'b0;
        exp_cmd = '0; exp_status = '0; exp_len = '0;
        set_exp(1'b0, 1'b0, 1'b0, '0, 1'b0);
        start_cycles = 0; abort_cnt = 0; obs_start = '0;
        obs_cmd = '0; obs_status = '0; obs_len = '0;
        chk_en = 1'b1;
        repeat (3) step();
        check("reset_resp_cmd", 32'(resp_cmd), 32'h0);
        check("reset_resp_status", 32'(resp_status), 32'h0);
        check("reset_resp_len", 32'(resp_len), 32'h0);
        resetn = 1'b1; enable = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();

        // SWJ_Clock, done three cycles after start, len 2.
        run_cmd(8'h11, 2, -1, 0, 10'd2, 0);
        check("pin_swj_start", 32'(obs_start), 32'h0020);
        check("pin_swj_start_cycles", 32'(start_cycles), 32'd1);
        check("pin_swj_cmd", 32'(obs_cmd), 32'h11);
        check("pin_swj_status", 32'(obs_status), 32'd0);
        check("pin_swj_len", 32'(obs_len), 32'd2);

        run_cmd(8'h7E, 0, -1, 0, 10'd9, 1);
        check("pin_unk_start_cycles", 32'(start_cycles), 32'd0);
        check("pin_unk_status", 32'(obs_status), 32'd1);
        check("pin_unk_len", 32'(obs_len), 32'd0);

        run_cmd(8'h05, -1, -1, 100, 10'd7, 0);
        check("pin_to_abort_cnt", 32'(abort_cnt), 32'd1);
        check("pin_to_status", 32'(obs_status), 32'd2);

        run_cmd(8'h12, 4, -1, 100, 10'd33, 0);
        check("pin_done_vs_to_abort_cnt", 32'(abort_cnt), 32'd0);
        check("pin_done_vs_to_status", 32'(obs_status), 32'd0);
        check("pin_done_vs_to_len", 32'(obs_len), 32'd33);

        run_cmd(8'h13, -1, 2, 0, 10'd1, 0);
        check("pin_en_abort_cnt", 32'(abort_cnt), 32'd1);
        check("pin_en_status", 32'(obs_status), 32'd3);

        run_cmd(8'h15, 1, -1, 50, 10'h3FF, 10);
        check("pin_wait_len", 32'(obs_len), 32'h3FF);

        // Reset while a worker is running.
        step();
        enable = 1'b1; dap_in_tvalid = 1'b1; dap_in_tdata = 8'h05;
        set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step();
        dap_in_tvalid = 1'b0;
        set_exp(1'b0, 1'b1, 1'b0, NW'(1) << 3, 1'b0);
        step();
        done = '0; worker_tready = 16'h0008;
        set_exp(1'b1, 1'b1, 1'b0, '0, 1'b0);
        step();
        resetn = 1'b0; enable = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_resp_cmd", 32'(resp_cmd), 32'h0);
        step();
        resetn = 1'b1; enable = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
        run_cmd(8'h02, 0, -1, 30, 10'd5, 2);
        check("pin_after_rst_cmd", 32'(obs_cmd), 32'h02);
        check("pin_after_rst_len", 32'(obs_len), 32'd5);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                rid = id_table[$urandom_range(0, NW-1)];
            end else begin
                rid = 8'($urandom);
                lookup(rid, h, ix);
                if (h) rid = 8'h7E;
            end
            run_cmd(rid,
                    ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 10)),
                    ($urandom_range(0, 9) < 7) ? -1 : int'($urandom_range(0, 10)),
                    int'($urandom_range(20, 100)),
                    LW'($urandom),
                    int'($urandom_range(0, 4)));
        end

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
